// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage HI/LO unit: funct codes, bus widths
// and divider state encodings.
package ex_muldiv_pkg;

    localparam int DATA_BUS  = 32;
    localparam int FUNCT_BUS = 6;

    localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_muldiv_div_unit.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// MULDIV_EARLY_OUT_EN lets trivial divides skip the iteration phase.
module div_unit
    import ex_muldiv_pkg::*;
#(
    parameter int W      = DATA_BUS,
    parameter int CYCLES = DATA_BUS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output div_state_e   state,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(CYCLES);

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q;
    logic [W-1:0]  rem_q, quo_q, dvs_q;
    logic [W:0]    shifted, diff;
    logic          fits;
    logic          early;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (divisor == '0) || (dividend < divisor);
`else
    assign early = 1'b0;
`endif

    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = shifted >= {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start)
                    state_d = early ? DIV_DONE : DIV_BUSY;
            end
            DIV_BUSY: begin
                if (abort)
                    state_d = DIV_IDLE;
                else if (count_q == CW'(CYCLES - 1))
                    state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= DIV_IDLE;
        else
            state_q <= state_d;
    end

    // Trivial early-out results match what 32 iterations would produce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else if (state_q == DIV_IDLE && start) begin
            count_q <= '0;
            dvs_q   <= divisor;
            if (early) begin
                quo_q <= (divisor == '0) ? '1 : '0;
                rem_q <= dividend;
            end else begin
                quo_q <= dividend;
                rem_q <= '0;
            end
        end else if (state_q == DIV_BUSY) begin
            count_q <= count_q + 1'b1;
            rem_q   <= fits ? diff[W-1:0] : shifted[W-1:0];
            quo_q   <= {quo_q[W-2:0], fits};
        end
    end

    assign state     = state_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: MULT/MULTU, DIV/DIVU, MTHI/MTLO and divide stall.
// Optional MULDIV_EARLY_OUT_EN shortens trivial divides to one stall cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  en_in,
    input  logic [FUNCT_BUS-1:0]  funct_in,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    output logic                  stall_request,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;

    div_state_e     div_state;
    logic           is_mthi, is_mtlo, is_mult, is_multu;
    logic           is_div, is_divu;
    logic           div_req;
    logic           neg_q_q, neg_r_q;
    logic [W-1:0]   abs_1, abs_2;
    logic [W-1:0]   quotient, remainder;
    logic [W-1:0]   quo_res, rem_res;
    logic [W-1:0]   hi_q, lo_q;
    logic [2*W-1:0] prod_s, prod_u;

    always_comb begin
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        if (en_in) begin
            case (funct_in)
                FUNCT_MTHI:  is_mthi  = 1'b1;
                FUNCT_MTLO:  is_mtlo  = 1'b1;
                FUNCT_MULT:  is_mult  = 1'b1;
                FUNCT_MULTU: is_multu = 1'b1;
                FUNCT_DIV:   is_div   = 1'b1;
                FUNCT_DIVU:  is_divu  = 1'b1;
                default: ;
            endcase
        end
    end

    // Only IDLE may launch; DONE still sees the same DIV and must not rerun it.
    assign div_req = (is_div || is_divu) && !flush && div_state == DIV_IDLE;

    assign abs_1 = (is_div && operand_1_in[W-1]) ? -operand_1_in : operand_1_in;
    assign abs_2 = (is_div && operand_2_in[W-1]) ? -operand_2_in : operand_2_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (div_req) begin
            neg_q_q <= is_div && (operand_1_in[W-1] ^ operand_2_in[W-1]);
            neg_r_q <= is_div && operand_1_in[W-1];
        end
    end

    div_unit #(
        .W      (W),
        .CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_req),
        .abort     (flush),
        .dividend  (abs_1),
        .divisor   (abs_2),
        .state     (div_state),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign quo_res = neg_q_q ? -quotient : quotient;
    assign rem_res = neg_r_q ? -remainder : remainder;

    assign prod_s = {{W{operand_1_in[W-1]}}, operand_1_in}
                  * {{W{operand_2_in[W-1]}}, operand_2_in};
    assign prod_u = {{W{1'b0}}, operand_1_in} * {{W{1'b0}}, operand_2_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!flush) begin
            if (div_state == DIV_DONE) begin
                hi_q <= rem_res;
                lo_q <= quo_res;
            end else if (div_state == DIV_IDLE) begin
                if (is_mthi)
                    hi_q <= operand_1_in;
                if (is_mtlo)
                    lo_q <= operand_1_in;
                if (is_mult)
                    {hi_q, lo_q} <= prod_s;
                if (is_multu)
                    {hi_q, lo_q} <= prod_u;
            end
        end
    end

    assign stall_request = !rst && !flush
                         && (div_req || div_state == DIV_BUSY);
    assign busy   = div_state != DIV_IDLE;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
